// File: rtl/kb_cmd_repeat_if.sv
// Keycode input and game command pulse bundle for kb_cmd_repeat.
// The keyboard side is master; the repeat engine is slave.
interface kb_cmd_repeat_if;
  logic [7:0] keycode;
  logic       enable;
  logic       cmd_left;
  logic       cmd_right;
  logic       cmd_rot;
  logic       cmd_down;
  logic       cmd_pause;
  logic [7:0] key_held;

  modport master (
    output keycode, enable,
    input  cmd_left, cmd_right, cmd_rot, cmd_down, cmd_pause, key_held
  );

  modport slave (
    input  keycode, enable,
    output cmd_left, cmd_right, cmd_rot, cmd_down, cmd_pause, key_held
  );
endinterface

// File: rtl/kb_cmd_repeat.sv
// Keycode synchroniser, glitch filter and auto-repeat engine.
// Produces one-cycle game command pulses in the game clock domain.
module kb_cmd_repeat #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DELAY_CYCLES  = 5_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_500_000,
  parameter int unsigned DOWN_CYCLES   = 1_250_000
) (
  input logic            clk,
  input logic            rst,
  kb_cmd_repeat_if.slave bus
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_ROT   = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_PAUSE = 8'h2C;

  // state | meaning: IDLE evaluate key_held | DELAY initial hold | REPEAT periodic | WAIT_REL no pulses
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DELAY    = 2'd1;
  localparam logic [1:0] ST_REPEAT   = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  logic [7:0]  sync1, sync2, held;
  logic [31:0] stab_cnt;
  logic        key_chg;
  logic [1:0]  state, state_nxt;
  logic [31:0] rpt_cnt, rpt_nxt, period, reload;
  logic [4:0]  key_cmd, pulse;
  logic        moving;

  // key_chg marks the cycle after an acceptance so the FSM restarts from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 8'h00;
      sync2    <= 8'h00;
      held     <= 8'h00;
      stab_cnt <= 32'd0;
      key_chg  <= 1'b0;
    end else begin
      sync1   <= bus.keycode;
      sync2   <= sync1;
      key_chg <= 1'b0;
      if (sync1 != sync2)
        stab_cnt <= 32'd0;
      else if (stab_cnt < STABLE_CYCLES)
        stab_cnt <= stab_cnt + 32'd1;
      if ((stab_cnt >= STABLE_CYCLES) && (sync2 != held)) begin
        held    <= sync2;
        key_chg <= 1'b1;
      end
    end
  end

  always_comb begin
    key_cmd = 5'b00000;
    moving  = 1'b0;
    case (held)
      KEY_LEFT:  begin key_cmd = 5'b10000; moving = 1'b1; end
      KEY_RIGHT: begin key_cmd = 5'b01000; moving = 1'b1; end
      KEY_ROT:   key_cmd = 5'b00100;
      KEY_DOWN:  begin key_cmd = 5'b00010; moving = 1'b1; end
      KEY_PAUSE: key_cmd = 5'b00001;
      default:   ;
    endcase
  end

  assign period = (held == KEY_DOWN) ? DOWN_CYCLES : REPEAT_CYCLES;
  assign reload = (state == ST_DELAY) ? DELAY_CYCLES : period;

  always_comb begin
    state_nxt = state;
    rpt_nxt   = rpt_cnt;
    pulse     = 5'b00000;
    if (key_chg || (state == ST_IDLE)) begin
      rpt_nxt = 32'd0;
      if (held == 8'h00) begin
        state_nxt = ST_IDLE;
      end else if (held == KEY_PAUSE) begin
        pulse     = key_cmd;
        state_nxt = ST_WAIT_REL;
      end else if (!bus.enable) begin
        state_nxt = ST_WAIT_REL;
      end else begin
        pulse     = key_cmd;
        state_nxt = moving ? ST_DELAY : ST_WAIT_REL;
      end
    end else if (!bus.enable) begin
      // leaving play mode drops any held movement until a new press
      state_nxt = ST_WAIT_REL;
    end else if ((state == ST_DELAY) || (state == ST_REPEAT)) begin
      if (rpt_cnt == reload - 32'd1) begin
        pulse     = key_cmd;
        rpt_nxt   = 32'd0;
        state_nxt = ST_REPEAT;
      end else begin
        rpt_nxt = rpt_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rpt_cnt       <= 32'd0;
      bus.cmd_left  <= 1'b0;
      bus.cmd_right <= 1'b0;
      bus.cmd_rot   <= 1'b0;
      bus.cmd_down  <= 1'b0;
      bus.cmd_pause <= 1'b0;
    end else begin
      state         <= state_nxt;
      rpt_cnt       <= rpt_nxt;
      bus.cmd_left  <= pulse[4];
      bus.cmd_right <= pulse[3];
      bus.cmd_rot   <= pulse[2];
      bus.cmd_down  <= pulse[1];
      bus.cmd_pause <= pulse[0];
    end
  end

  assign bus.key_held = held;

endmodule
